// File: rtl/vending_ctrl_param_pkg.sv
// vending_ctrl_param_pkg: shared state encoding and keypad constants for the vending controller
package vending_ctrl_param_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DIG1, S_DIG2, S_CHECK, S_WAIT_TRAN, S_VEND, S_DOOR_WAIT} state_t;
  localparam int IDX_W = 7;
  localparam logic [3:0] MAX_DIGIT = 4'd9;
  localparam logic [IDX_W-1:0] RADIX = 7'd10;
endpackage

// File: rtl/vending_ctrl_param_if.sv
// vending_ctrl_param_if: keypad/payment/door inputs and status outputs of the vending controller
interface vending_ctrl_param_if #(parameter int COST_W = 3);
  logic reload_i;
  logic card_in_i;
  logic [3:0] item_code_i;
  logic key_press_i;
  logic valid_tran_i;
  logic door_open_i;
  logic vend_o;
  logic invalid_sel_o;
  logic sold_out_o;
  logic [COST_W-1:0] cost_o;
  logic failed_tran_o;
  modport master (
    output reload_i, card_in_i, item_code_i, key_press_i, valid_tran_i, door_open_i,
    input vend_o, invalid_sel_o, sold_out_o, cost_o, failed_tran_o
  );
  modport slave (
    input reload_i, card_in_i, item_code_i, key_press_i, valid_tran_i, door_open_i,
    output vend_o, invalid_sel_o, sold_out_o, cost_o, failed_tran_o
  );
endinterface

// File: rtl/vending_ctrl_param_stock.sv
// vend_stock_bank: per-item stock counters with bulk reload and saturating single decrement
module vend_stock_bank
  import vending_ctrl_param_pkg::*;
#(
  parameter int NUM_ITEMS  = 20,
  parameter int STOCK_W    = 4,
  parameter int RELOAD_QTY = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_all_i,
  input  logic             dec_en_i,
  input  logic [IDX_W-1:0] dec_idx_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_empty_o
);
  // Indices past NUM_ITEMS read as empty so the lookup needs no range guard
  logic [2**IDX_W-1:0] empty_v;
  for (genvar i = 0; i < 2**IDX_W; i++) begin : g_cnt
    if (i < NUM_ITEMS) begin : g_real
      logic [STOCK_W-1:0] stock_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) stock_q <= '0;
        else if (load_all_i) stock_q <= STOCK_W'(RELOAD_QTY);
        else if (dec_en_i && dec_idx_i == IDX_W'(i) && stock_q != '0) stock_q <= stock_q - STOCK_W'(1);
      assign empty_v[i] = stock_q == '0;
    end else begin : g_pad
      assign empty_v[i] = 1'b1;
    end
  end
  assign rd_empty_o = empty_v[rd_idx_i];
endmodule

// File: rtl/vending_ctrl_param.sv
// vending_ctrl_param: card-operated vending FSM with two-digit selection, cost bands, stock and timeouts
module vending_ctrl_param
  import vending_ctrl_param_pkg::*;
#(
  parameter int NUM_ITEMS   = 20,
  parameter int GROUP_SIZE  = 4,
  parameter int COST_W      = 3,
  parameter int STOCK_W     = 4,
  parameter int RELOAD_QTY  = 10,
  parameter int TIMEOUT_CYC = 5
) (
  input logic clk,
  input logic rst,
  vending_ctrl_param_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CMAX = 2**COST_W - 1;
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q;
  logic card_q, key_q;
  logic [3:0] d1_q, d1_d, d2_q, d2_d;
  logic vend_q, vend_d, inv_q, inv_d, so_q, so_d, ft_q, ft_d;
  logic [COST_W-1:0] cost_q, cost_d, band;
  logic [IDX_W-1:0] idx, band_raw;
  logic card_rise, key_rise, expire, bad_digit, bad_idx, rd_empty;
  assign card_rise = bus.card_in_i & ~card_q;
  assign key_rise  = bus.key_press_i & ~key_q;
  assign expire    = tmr_q == TW'(TIMEOUT_CYC - 1);
  assign bad_digit = bus.item_code_i > MAX_DIGIT;
  assign idx       = IDX_W'(d1_q) * RADIX + IDX_W'(d2_q);
  assign bad_idx   = idx >= IDX_W'(NUM_ITEMS);
  assign band_raw  = idx / IDX_W'(GROUP_SIZE) + IDX_W'(1);
  assign band      = band_raw > IDX_W'(CMAX) ? COST_W'(CMAX) : COST_W'(band_raw);
  vend_stock_bank #(
    .NUM_ITEMS(NUM_ITEMS), .STOCK_W(STOCK_W), .RELOAD_QTY(RELOAD_QTY)
  ) u_bank (
    .clk(clk), .rst(rst),
    .load_all_i(state_q == S_IDLE && bus.reload_i),
    .dec_en_i(state_q == S_WAIT_TRAN && bus.valid_tran_i),
    .dec_idx_i(idx), .rd_idx_i(idx), .rd_empty_o(rd_empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      card_q  <= 1'b0;
      key_q   <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      vend_q  <= 1'b0;
      inv_q   <= 1'b0;
      so_q    <= 1'b0;
      ft_q    <= 1'b0;
      cost_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= state_d != state_q ? '0 : tmr_q + TW'(1);
      card_q  <= bus.card_in_i;
      key_q   <= bus.key_press_i;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      vend_q  <= vend_d;
      inv_q   <= inv_d;
      so_q    <= so_d;
      ft_q    <= ft_d;
      cost_q  <= cost_d;
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      state_d = card_rise ? S_DIG1 : S_IDLE;
      S_DIG1:      state_d = key_rise ? (bad_digit ? S_IDLE : S_DIG2) : (expire ? S_IDLE : S_DIG1);
      S_DIG2:      state_d = key_rise ? (bad_digit ? S_IDLE : S_CHECK) : (expire ? S_IDLE : S_DIG2);
      S_CHECK:     state_d = (bad_idx || rd_empty) ? S_IDLE : S_WAIT_TRAN;
      S_WAIT_TRAN: state_d = bus.valid_tran_i ? S_VEND : (expire ? S_IDLE : S_WAIT_TRAN);
      S_VEND:      state_d = bus.door_open_i ? S_DOOR_WAIT : (expire ? S_IDLE : S_VEND);
      S_DOOR_WAIT: state_d = bus.door_open_i ? S_DOOR_WAIT : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end
  always_comb begin
    d1_d   = d1_q;
    d2_d   = d2_q;
    vend_d = vend_q;
    inv_d  = inv_q;
    so_d   = so_q;
    ft_d   = ft_q;
    cost_d = cost_q;
    unique case (state_q)
      S_IDLE: if (card_rise) begin
        inv_d  = 1'b0;
        so_d   = 1'b0;
        ft_d   = 1'b0;
        cost_d = '0;
      end
      S_DIG1: begin
        d1_d  = key_rise && !bad_digit ? bus.item_code_i : d1_q;
        inv_d = key_rise ? bad_digit : expire;
      end
      S_DIG2: begin
        d2_d  = key_rise && !bad_digit ? bus.item_code_i : d2_q;
        inv_d = key_rise ? bad_digit : expire;
      end
      S_CHECK: begin
        inv_d  = bad_idx;
        so_d   = !bad_idx && rd_empty;
        cost_d = bad_idx || rd_empty ? cost_q : band;
      end
      S_WAIT_TRAN: if (bus.valid_tran_i) vend_d = 1'b1;
      else if (expire) begin
        ft_d   = 1'b1;
        cost_d = '0;
      end
      // An unopened door still counts as dispensed; only VEND drops
      S_VEND: vend_d = bus.door_open_i || !expire;
      S_DOOR_WAIT: if (!bus.door_open_i) begin
        vend_d = 1'b0;
        cost_d = '0;
      end
      default: ;
    endcase
  end
  assign bus.vend_o        = vend_q;
  assign bus.invalid_sel_o = inv_q;
  assign bus.sold_out_o    = so_q;
  assign bus.failed_tran_o = ft_q;
  assign bus.cost_o        = cost_q;
endmodule
